// File: rtl/gpio_key_in.sv
// gpio_key_in: memory-mapped push-button/switch input port with synchronizer, debounce and sticky press flags
module gpio_key_in #(
    parameter int NKEY = 4,
    parameter int NSW = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            wmem,
    input  logic [31:0]     A_KEY,
    input  logic [31:0]     Di,
    output logic [31:0]     Do_Key,
    input  logic [NKEY-1:0] key_in,
    input  logic [NSW-1:0]  sw_in
);
    localparam int N = NKEY + NSW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // keys come out of reset at the released (high) level so nothing reads as pressed
    localparam logic [N-1:0] RST_V = {{NSW{1'b0}}, {NKEY{1'b1}}};
    logic [N-1:0] s1, s2, stable, upd;
    logic [CW-1:0] cnt [N];
    logic [NKEY-1:0] pressed, ev, pend, clr;
    logic [7:0] press_cnt, n_ev;
    logic en, pol, wr_pend, wr_ctrl, unused_ok;
    assign pressed = stable[NKEY-1:0] ^ {NKEY{pol}};
    assign ev = upd[NKEY-1:0] & ~pressed & {NKEY{en}};
    assign wr_pend = wmem && A_KEY[3:0] == 4'h1;
    assign wr_ctrl = wmem && A_KEY[3:0] == 4'h4;
    assign clr = wr_pend ? Di[NKEY-1:0] : '0;
    assign unused_ok = ^{A_KEY[31:4], Di};
    always_comb begin
        upd = '0;
        n_ev = '0;
        for (int i = 0; i < N; i++)
            upd[i] = s2[i] != stable[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
        for (int i = 0; i < NKEY; i++)
            n_ev = n_ev + 8'(ev[i]);
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            s1 <= RST_V;
            s2 <= RST_V;
            stable <= RST_V;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            pend <= '0;
            press_cnt <= '0;
            en <= 1'b0;
            pol <= 1'b1;
        end else begin
            s1 <= {sw_in, key_in};
            s2 <= s1;
            for (int i = 0; i < N; i++)
                cnt[i] <= (s2[i] == stable[i] || upd[i]) ? '0 : cnt[i] + 1'b1;
            stable <= stable ^ upd;
            pend <= (pend & ~clr) | ev;
            press_cnt <= press_cnt + n_ev;
            if (wr_ctrl) {pol, en} <= Di[1:0];
        end
    end
    assign Do_Key = A_KEY[3:0] == 4'h0 ? 32'(pressed) :
                    A_KEY[3:0] == 4'h1 ? 32'(pend) :
                    A_KEY[3:0] == 4'h2 ? 32'(stable[N-1:NKEY]) :
                    A_KEY[3:0] == 4'h3 ? 32'(press_cnt) :
                    A_KEY[3:0] == 4'h4 ? {30'b0, pol, en} : 32'h0;
endmodule
